// File: rtl/elastic_skid_buffer_if.sv
// elastic_skid_buffer_if: upstream/downstream valid-ready handshake bundle for elastic_skid_buffer
interface elastic_skid_buffer_if #(parameter int DATA_WIDTH = 32);
  logic [DATA_WIDTH-1:0] ins;
  logic [DATA_WIDTH-1:0] outs;
  logic ins_valid;
  logic ins_ready;
  logic outs_valid;
  logic outs_ready;
  modport master(output ins, ins_valid, outs_ready, input ins_ready, outs, outs_valid);
  modport slave(input ins, ins_valid, outs_ready, output ins_ready, outs, outs_valid);
endinterface

// File: rtl/elastic_skid_buffer.sv
// elastic_skid_buffer: two-entry fully registered skid buffer; ELASTIC_SKID_BUFFER_STATS_EN adds stall_count
module elastic_skid_buffer #(parameter int DATA_WIDTH = 32) (
  input logic clk,
  input logic rst,
  elastic_skid_buffer_if.slave bus
`ifdef ELASTIC_SKID_BUFFER_STATS_EN
  ,
  output logic [31:0] stall_count
`endif
);
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;
  state_t state;
  logic [DATA_WIDTH-1:0] main_q, skid_q;
  logic main_v, skid_v;
  logic in_fire, out_fire;
  assign in_fire = bus.ins_valid & ~skid_v;
  assign out_fire = main_v & bus.outs_ready;
  assign bus.outs = main_q;
  assign bus.outs_valid = main_v;
  assign bus.ins_ready = ~skid_v;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      main_v <= 1'b0;
      skid_v <= 1'b0;
    end else
      case (state)
        EMPTY: if (in_fire) begin
          main_q <= bus.ins;
          main_v <= 1'b1;
          state <= BUSY;
        end
        BUSY: if (in_fire && out_fire) main_q <= bus.ins;
          else if (in_fire) begin
            skid_q <= bus.ins;
            skid_v <= 1'b1;
            state <= FULL;
          end else if (out_fire) begin
            main_v <= 1'b0;
            state <= EMPTY;
          end
        FULL: if (out_fire) begin
          main_q <= skid_q;
          skid_v <= 1'b0;
          state <= BUSY;
        end
        default: state <= EMPTY;
      endcase
`ifdef ELASTIC_SKID_BUFFER_STATS_EN
  always_ff @(posedge clk or negedge rst)
    if (!rst) stall_count <= '0;
    else if (main_v && !bus.outs_ready && stall_count != '1) stall_count <= stall_count + 32'd1;
`endif
endmodule

// File: tb/tb_elastic_skid_buffer.sv
// tb_elastic_skid_buffer: scoreboard bench for elastic_skid_buffer
module tb_elastic_skid_buffer;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int n_chk = 0;
  int n_pass = 0;
  logic [31:0] q[$];
  logic [31:0] stall_m = 0;
  elastic_skid_buffer_if #(.DATA_WIDTH(32)) bus();
`ifdef ELASTIC_SKID_BUFFER_STATS_EN
  logic [31:0] stall_count;
  elastic_skid_buffer #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave), .stall_count(stall_count));
`else
  elastic_skid_buffer #(.DATA_WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
`endif
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic cyc(input logic v, input logic [31:0] d, input logic r);
    logic [31:0] e;
    bus.ins_valid = v;
    bus.ins = d;
    bus.outs_ready = r;
    #1;
    if (bus.outs_valid && r) begin
      if (q.size() == 0) chk("underflow", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        chk("data", {32'd0, bus.outs}, {32'd0, e});
      end
    end
    if (bus.outs_valid && !r && stall_m != 32'hFFFFFFFF) stall_m++;
    if (v && bus.ins_ready) q.push_back(d);
    @(posedge clk);
    #1;
    chk("occupancy<=2", {63'd0, q.size() <= 2}, 64'd1);
    chk("ins_ready", {63'd0, bus.ins_ready}, {63'd0, q.size() < 2});
    chk("outs_valid", {63'd0, bus.outs_valid}, {63'd0, q.size() != 0});
    if (q.size() != 0) chk("head", {32'd0, bus.outs}, {32'd0, q[0]});
`ifdef ELASTIC_SKID_BUFFER_STATS_EN
    chk("stall_count", {32'd0, stall_count}, {32'd0, stall_m});
`endif
    @(negedge clk);
  endtask
  task automatic check_reset_vals(input string tag);
    chk({tag, "_valid"}, {63'd0, bus.outs_valid}, 64'd0);
    chk({tag, "_outs"}, {32'd0, bus.outs}, 64'd0);
    chk({tag, "_ready"}, {63'd0, bus.ins_ready}, 64'd1);
  endtask
  initial begin
    bus.ins_valid = 1'b0;
    bus.ins = '0;
    bus.outs_ready = 1'b0;
    #1;
    check_reset_vals("rst");
`ifdef ELASTIC_SKID_BUFFER_STATS_EN
    chk("rst_stall", {32'd0, stall_count}, 64'd0);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) cyc(1'b0, 32'hDEAD, 1'b1);
    check_reset_vals("idle");
    for (int i = 1; i <= 8; i++) cyc(1'b1, i, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'hA, 1'b0);
    cyc(1'b1, 32'hB, 1'b0);
    cyc(1'b1, 32'hC, 1'b0);
    chk("full_ready", {63'd0, bus.ins_ready}, 64'd0);
    chk("full_occ", q.size(), 64'd2);
    repeat (3) cyc(1'b1, 32'hC, 1'b1);
    repeat (2) cyc(1'b0, 32'h0, 1'b1);
    cyc(1'b1, 32'h55, 1'b0);
    repeat (5) cyc(1'b0, 32'h0, 1'b0);
    chk("hold_outs", {32'd0, bus.outs}, 64'h55);
    cyc(1'b0, 32'h0, 1'b1);
`ifdef ELASTIC_SKID_BUFFER_STATS_EN
    chk("stall7", {32'd0, stall_count}, 64'd7);
`endif
    cyc(1'b1, 32'h11, 1'b0);
    cyc(1'b1, 32'h22, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_reset_vals("async_rst");
    q.delete();
    stall_m = 0;
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10000; i++)
      cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6);
    repeat (4) cyc(1'b0, 32'h0, 1'b1);
    chk("drained", q.size(), 64'd0);
`ifdef ELASTIC_SKID_BUFFER_STATS_EN
    cyc(1'b1, 32'h77, 1'b0);
    dut.stall_count = 32'hFFFFFFFC;
    stall_m = 32'hFFFFFFFC;
    repeat (6) cyc(1'b0, 32'h0, 1'b0);
    chk("stall_sat", {32'd0, stall_count}, 64'hFFFFFFFF);
    cyc(1'b0, 32'h0, 1'b1);
`endif
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
